gcd_engine: RTL
===============

GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start_valid  input  1  operand pair offered.
REQ-005 SHALL have port start_ready  output  1  engine accepts operands (IDLE).
REQ-006 SHALL have port a_in  input  WIDTH  first operand, unsigned.
REQ-007 SHALL have port b_in  input  WIDTH  second operand, unsigned.
REQ-008 SHALL have port done_valid  output  1  result available (DONE).
REQ-009 SHALL have port done_ready  input  1  consumer takes result.
REQ-010 SHALL have port result  output  WIDTH  gcd(a,b), held while done_valid.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE; start_ready = (state==IDLE), done_valid = (state==DONE), both combinational from state.
REQ-012 SHALL, on an edge with start_valid && start_ready, load x<=a_in, y<=b_in and go IDLE->CALC; start_valid outside IDLE is ignored.
REQ-013 SHALL, in CALC, if x==0 or y==0 or x==y, register result<=x|y and go to DONE on that edge.
REQ-014 SHALL, in CALC otherwise, perform one subtraction per cycle: x>y -> x<=x-y; else y<=y-x; state stays CALC.
REQ-015 SHALL use unsigned WIDTH-bit arithmetic only; subtraction of smaller from larger never underflows.
REQ-016 SHALL give gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0.
REQ-017 SHALL have latency: done_valid rises N+1 edges after the accept edge, N = subtraction count.
REQ-018 SHALL hold result and done_valid stable in DONE until an edge with done_ready high, then go DONE->IDLE; start_ready is high from the following cycle.
REQ-019 SHALL accept no new operands in the DONE->IDLE transition cycle (no same-cycle turnaround).

Reset
REQ-020 SHALL, on rst high, immediately force state=IDLE, x=0, y=0, result=0; start_ready=1, done_valid=0.
REQ-021 SHALL abort any CALC or DONE operation on reset with no result produced; first accept is possible on the first edge after rst falls.

Configuration
REQ-022 SHALL, with GCD_ITER_COUNT_EN defined, add output iter_count (WIDTH bits): cleared on accept and reset, incremented per subtraction, held in DONE.
REQ-023 SHALL, without GCD_ITER_COUNT_EN, omit the iter_count port and counter; all other behaviour identical.

Structure
REQ-024 SHALL place the FSM state enum type (IDLE, CALC, DONE) and the default WIDTH constant in shared package gcd_pkg.
REQ-025 SHALL place compare/select/subtract logic in sub-module gcd_datapath (x, y in; next x, next y, done flag out); the FSM and registers stay in gcd_engine.

Verification
REQ-026 SHALL cover a=12, b=8 -> accept at E0, subtractions at E1 and E2, done_valid after E3, result=4, iter_count=2.
REQ-027 SHALL cover a=15, b=1 -> 14 subtractions, done_valid after E15, result=1, iter_count=14.
REQ-028 SHALL cover a=0, b=9 and a=7, b=7 -> done_valid after E1, result=9 and 7 respectively, iter_count=0.
REQ-029 SHALL cover a=9, b=6 with done_ready low 5 cycles -> result=3 and done_valid held; IDLE one edge after done_ready rises.
REQ-030 SHALL cover a=15, b=2 with rst pulsed in CALC -> outputs at reset values at once, no done_valid; next pair 6,4 -> result=2.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine.
package gcd_pkg;

  localparam int unsigned GcdDefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_datapath.sv
// Compare/select/subtract step of the subtractive GCD: one subtraction per call.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GcdDefaultWidth
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] x_next_o,
  output logic [WIDTH-1:0] y_next_o,
  output logic             done_o
);

  always_comb begin
    x_next_o = x_i;
    y_next_o = y_i;
    done_o   = (x_i == '0) || (y_i == '0) || (x_i == y_i);
    // Always subtract the smaller from the larger, so no underflow is possible.
    if (!done_o) begin
      if (x_i > y_i) begin
        x_next_o = x_i - y_i;
      end else begin
        y_next_o = y_i - x_i;
      end
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD engine with valid/ready handshakes on operands and result.
// Define GCD_ITER_COUNT_EN to add the iter_count subtraction-counter output.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GcdDefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_count
`endif
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] x_next, y_next;
  logic             step_done;

  gcd_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .x_i      (x_q),
    .y_i      (y_q),
    .x_next_o (x_next),
    .y_next_o (y_next),
    .done_o   (step_done)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          x_d     = a_in;
          y_d     = b_in;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (step_done) begin
          result_d = x_q | y_q;
          state_d  = StDone;
        end else begin
          x_d = x_next;
          y_d = y_next;
        end
      end
      StDone: begin
        // No new accept here; start_ready only rises once back in idle.
        if (done_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
    end
  end

  assign start_ready = (state_q == StIdle);
  assign done_valid  = (state_q == StDone);
  assign result      = result_q;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && start_valid) begin
      cnt_d = '0;
    end else if (state_q == StCalc && !step_done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign iter_count = cnt_q;
`endif

endmodule
